// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, redirect
// selection and the instruction-memory request/ready handshake.

module if_fetch_rca #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);
    logic [N-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    // Ripple chain; the final carry-out is intentionally not formed so the sum wraps.
    for (genvar g = 0; g < int'(N); g++) begin : g_bit
        assign o_sum[g] = i_a[g] ^ i_b[g] ^ w_carry[g];
        if (g < int'(N) - 1) begin : g_carry
            assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
        end
    end
endmodule

module if_fetch_stage #(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [31:0]  NOP      = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         branch_taken_i,
    input  logic [N-1:0] branch_target_i,
    input  logic         jump_i,
    input  logic [N-1:0] jump_target_i,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_ready_i,
    input  logic [31:0]  imem_rdata_i,
    output logic [N-1:0] pc_o,
    output logic [31:0]  ifid_instr_o,
    output logic [N-1:0] ifid_pc4_o,
    output logic         ifid_valid_o
);
    localparam logic [1:0]   S_IDLE  = 2'd0;
    localparam logic [1:0]   S_FETCH = 2'd1;
    localparam logic [1:0]   S_DRAIN = 2'd2;
    localparam logic [N-1:0] PC_INC  = N'(4);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_nxt;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_nxt;
    logic         r_req;
    logic         w_req_nxt;
    logic [31:0]  r_instr;
    logic [31:0]  w_instr_nxt;
    logic [N-1:0] r_pc4;
    logic [N-1:0] w_pc4_nxt;
    logic         r_valid;
    logic         w_valid_nxt;
    logic         w_bubble;
    logic         w_redir;
    logic [N-1:0] w_raw_target;
    logic [N-1:0] w_target;
    logic [N-1:0] w_pc_plus4;

    if_fetch_rca #(.N(N)) u_pc_adder (
        .i_a   (r_pc),
        .i_b   (PC_INC),
        .o_sum (w_pc_plus4)
    );

    // Branch wins over jump; targets are forced word-aligned.
    assign w_redir      = branch_taken_i | jump_i;
    assign w_raw_target = branch_taken_i ? branch_target_i : jump_target_i;
    assign w_target     = {w_raw_target[N-1:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        w_bubble    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_redir && (imem_ready_i || !r_req)) begin
                    w_pc_nxt = w_target;
                    w_bubble = 1'b1;
                end else if (w_redir) begin
                    // Outstanding request must complete before the PC may move.
                    w_pend_nxt  = w_target;
                    w_bubble    = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (stall_i) begin
                    w_pc_nxt = r_pc;
                end else if (imem_ready_i) begin
                    w_pc_nxt    = w_pc_plus4;
                    w_instr_nxt = imem_rdata_i;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_bubble = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_redir) begin
                    w_pend_nxt = w_target;
                end
                if (imem_ready_i) begin
                    w_pc_nxt    = w_redir ? w_target : r_pend;
                    w_state_nxt = S_FETCH;
                end
                if (!stall_i || w_redir) begin
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_bubble) begin
            w_instr_nxt = NOP;
            w_pc4_nxt   = '0;
            w_valid_nxt = 1'b0;
        end

        w_req_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
            r_req   <= 1'b0;
            r_instr <= NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_req   <= w_req_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // The PC register is not updated while a request is pending, so it doubles as the address.
    assign imem_req_o   = r_req;
    assign imem_addr_o  = r_pc;
    assign pc_o         = r_pc;
    assign ifid_instr_o = r_instr;
    assign ifid_pc4_o   = r_pc4;
    assign ifid_valid_o = r_valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch stage.

module tb_if_fetch_stage;
    localparam logic [31:0] NOP_W   = 32'h0000_0000;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, br, jmp, rdy;
    logic [31:0] br_t, j_t, rdata;
    logic        req;
    logic [31:0] addr, pc, instr, pc4;
    logic        valid;

    logic        rst2, rdy2, zero1;
    logic [31:0] rdata2, zero32;
    logic        req2, valid2;
    logic [31:0] addr2, pc2, instr2, pc42;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_pend, m_instr, m_pc4;
    logic        m_valid, m_active, m_drain;

    if_fetch_stage #(.N(32), .RESET_PC(RST_PC), .NOP(NOP_W)) dut (
        .clk(clk), .rst(rst), .stall_i(stall),
        .branch_taken_i(br), .branch_target_i(br_t),
        .jump_i(jmp), .jump_target_i(j_t),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_ready_i(rdy), .imem_rdata_i(rdata),
        .pc_o(pc), .ifid_instr_o(instr), .ifid_pc4_o(pc4), .ifid_valid_o(valid)
    );

    if_fetch_stage #(.N(32), .RESET_PC(WRAP_PC), .NOP(NOP_W)) dut_wrap (
        .clk(clk), .rst(rst2), .stall_i(zero1),
        .branch_taken_i(zero1), .branch_target_i(zero32),
        .jump_i(zero1), .jump_target_i(zero32),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ready_i(rdy2), .imem_rdata_i(rdata2),
        .pc_o(pc2), .ifid_instr_o(instr2), .ifid_pc4_o(pc42), .ifid_valid_o(valid2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_bubble();
        m_instr = NOP_W;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock of the fetch stage, from the rules for each mode of operation.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = br | jmp;
        tgt   = (br ? br_t : j_t) & 32'hFFFF_FFFC;
        if (rst) begin
            m_pc = RST_PC; m_bubble(); m_active = 1'b0; m_drain = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (m_drain) begin
            if (redir) m_pend = tgt;
            if (rdy) begin
                m_pc    = m_pend;
                m_drain = 1'b0;
            end
            if (!stall || redir) m_bubble();
        end else if (redir && rdy) begin
            m_pc = tgt; m_bubble();
        end else if (redir) begin
            m_pend = tgt; m_drain = 1'b1; m_bubble();
        end else if (stall) begin
            m_pc = m_pc;
        end else if (rdy) begin
            m_instr = rdata;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else begin
            m_bubble();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_pc",    pc,    m_pc);
        check("model_addr",  addr,  m_pc);
        check("model_req",   {31'h0, req},   {31'h0, m_active});
        check("model_instr", instr, m_instr);
        check("model_pc4",   pc4,   m_pc4);
        check("model_valid", {31'h0, valid}, {31'h0, m_valid});
    endtask

    task automatic quiet();
        stall = 1'b0; br = 1'b0; jmp = 1'b0; br_t = 32'h0; j_t = 32'h0;
    endtask

    initial begin
        rst = 1'b1; quiet(); rdy = 1'b0; rdata = 32'h0;
        rst2 = 1'b1; rdy2 = 1'b1; rdata2 = 32'h1111_1111; zero1 = 1'b0; zero32 = 32'h0;
        m_pc = RST_PC; m_pend = 32'h0; m_active = 1'b0; m_drain = 1'b0; m_bubble();

        // Reset and start-up
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_req", {31'h0, req}, 32'h0);
        rst = 1'b0;
        tick();
        check("startup_req", {31'h0, req}, 32'h1);

        // Back-to-back fetches
        rdy = 1'b1; rdata = 32'h2001_000A;
        tick();
        check("f1_instr", instr, 32'h2001_000A);
        check("f1_pc4", pc4, 32'h4);
        rdata = 32'h2002_000B;
        tick();
        check("f2_instr", instr, 32'h2002_000B);
        check("f2_pc4", pc4, 32'h8);
        check("f2_pc", pc, 32'h8);

        // Stall holds PC and IF/ID, returned word is dropped
        stall = 1'b1; rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        check("stall_pc", pc, 32'h8);
        check("stall_instr", instr, 32'h2002_000B);
        stall = 1'b0; rdata = 32'h2003_000C;
        tick();
        check("refetch_instr", instr, 32'h2003_000C);
        check("refetch_pc4", pc4, 32'hC);

        // Simultaneous branch and jump: branch wins
        br = 1'b1; br_t = 32'h40; jmp = 1'b1; j_t = 32'h80;
        tick();
        check("prio_pc", pc, 32'h40);
        check("prio_valid", {31'h0, valid}, 32'h0);

        // Redirect while memory is not ready goes through drain
        quiet(); br = 1'b1; br_t = 32'h10;
        tick();
        check("to10_pc", pc, 32'h10);
        quiet(); rdy = 1'b0; jmp = 1'b1; j_t = 32'h83;
        tick();
        check("drain_addr0", addr, 32'h10);
        quiet();
        repeat (2) begin
            tick();
            check("drain_addr", addr, 32'h10);
            check("drain_req", {31'h0, req}, 32'h1);
        end
        rdy = 1'b1; rdata = 32'hBAD0_BAD0;
        tick();
        check("drain_pc", pc, 32'h80);
        check("drain_discard", {31'h0, valid}, 32'h0);
        rdata = 32'h2004_000D;
        tick();
        check("post_drain_pc4", pc4, 32'h84);

        // Reset in the middle of a drain
        rdy = 1'b0; jmp = 1'b1; j_t = 32'h200;
        tick();
        quiet(); rst = 1'b1;
        tick();
        check("rst_drain_req", {31'h0, req}, 32'h0);
        check("rst_drain_pc", pc, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_drain_fetch", {31'h0, req}, 32'h1);

        // PC wraps past the top of the address space
        @(negedge clk); rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b0;
        @(posedge clk); #1;
        check("wrap_start_pc", pc2, WRAP_PC);
        check("wrap_start_addr", addr2, WRAP_PC);
        @(posedge clk); #1;
        check("wrap_pc", pc2, 32'h0);
        check("wrap_pc4", pc42, 32'h0);
        check("wrap_valid", {31'h0, valid2}, 32'h1);
        check("wrap_instr", instr2, 32'h1111_1111);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom % 97) == 0;
            stall = ($urandom % 4) == 0;
            br    = ($urandom % 8) == 0;
            jmp   = ($urandom % 8) == 0;
            rdy   = ($urandom % 3) != 0;
            br_t  = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 + ($urandom % 8) : $urandom;
            j_t   = $urandom;
            rdata = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
